// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file port arbiter and its round-robin picker.
package regfile_pkg;

    localparam int RF_DW    = 16;
    localparam int RF_AW    = 4;
    localparam int RF_NREGS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // 0 = core datapath, 1 = debug/load port
    typedef logic req_id_t;

endpackage

// File: rtl/rr_select.sv
// Combinational 2-way round-robin winner picker: on contention the requester that did not win last time goes.
module rr_select
    import regfile_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  req_id_t rr_ptr,
    output req_id_t win_id,
    output logic    any
);

    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            win_id = ~rr_ptr;
        end else begin
            win_id = req1;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single register-file port between core (0) and debug (1): IDLE -> ACCESS -> RESP.
// Define REGFILE_ARB_LOCK_EN to add lock0/lock1, letting a winner keep the port for read-modify-write.
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int DW    = RF_DW,
    parameter int AW    = RF_AW,
    parameter int NREGS = RF_NREGS
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] rf_sel,
    output logic          rf_we,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata
);

    arb_state_t    state_q, state_d;
    req_id_t       rr_ptr_q, rr_ptr_d;
    req_id_t       win_q, win_d;
    logic          we_q, we_d;
    logic          legal_q, legal_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_sel_q, rf_sel_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          pick_req0, pick_req1, pick_any;
    req_id_t       pick_id;
    logic          pick_we, pick_legal;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_wdata;

`ifdef REGFILE_ARB_LOCK_EN
    logic lock_q, lock_d;

    // While locked, only the previous winner is allowed to compete.
    assign pick_req0 = req0 & ~(lock_q & win_q);
    assign pick_req1 = req1 & ~(lock_q & ~win_q);
`else
    assign pick_req0 = req0;
    assign pick_req1 = req1;
`endif

    rr_select u_rr_select (
        .req0   (pick_req0),
        .req1   (pick_req1),
        .rr_ptr (rr_ptr_q),
        .win_id (pick_id),
        .any    (pick_any)
    );

    assign pick_we    = pick_id ? we1    : we0;
    assign pick_addr  = pick_id ? addr1  : addr0;
    assign pick_wdata = pick_id ? wdata1 : wdata0;
    assign pick_legal = (int'(pick_addr) < NREGS);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        we_d       = we_q;
        legal_d    = legal_q;
        rf_sel_d   = rf_sel_q;
        rf_wdata_d = rf_wdata_q;
        rdata_d    = rdata_q;
        rf_we_d    = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
        lock_d     = lock_q;
`endif
        case (state_q)
            IDLE: begin
                // Port controls are registered here so they are valid throughout ACCESS.
                if (pick_any) begin
                    win_d    = pick_id;
                    rr_ptr_d = pick_id;
                    we_d     = pick_we;
                    legal_d  = pick_legal;
                    rf_sel_d = pick_legal ? pick_addr : '0;
                    rf_we_d  = pick_we & pick_legal;
                    if (pick_legal) begin
                        rf_wdata_d = pick_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = we_q ? '0 : rf_rdata;
                ack0_d  = ~win_q;
                ack1_d  = win_q;
                err0_d  = ~win_q & ~legal_q;
                err1_d  = win_q & ~legal_q;
                state_d = RESP;
            end
            RESP: begin
`ifdef REGFILE_ARB_LOCK_EN
                lock_d = win_q ? lock1 : lock0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            legal_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_sel_q   <= '0;
            rf_wdata_q <= '0;
            rdata_q    <= '0;
`ifdef REGFILE_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            we_q       <= we_d;
            legal_q    <= legal_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rf_we_q    <= rf_we_d;
            rf_sel_q   <= rf_sel_d;
            rf_wdata_q <= rf_wdata_d;
            rdata_q    <= rdata_d;
`ifdef REGFILE_ARB_LOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;
    assign rdata    = rdata_q;
    assign rf_sel   = rf_sel_q;
    assign rf_we    = rf_we_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter: a behavioural model predicts each grant and response,
// a negedge monitor checks every ack; REGFILE_ARB_LOCK_EN adds a lock scenario and random locks.
module tb_regfile_port_arbiter;

    typedef struct {
        bit          id;
        bit          err;
        logic [15:0] rdata;
    } exp_t;

    logic        CLK;
    logic        RST_N;
    logic        req   [2];
    logic        we    [2];
    logic [3:0]  addr  [2];
    logic [15:0] wdata [2];
    logic        lock  [2];
    logic        ack0, ack1, err0, err1, rf_we;
    logic [15:0] rdata, rf_wdata, rf_rdata;
    logic [3:0]  rf_sel;

    logic [15:0] env_mem [10];
    logic [15:0] ref_mem [10];
    exp_t        exp_q [$];
    bit          m_last;
    bit          m_lock_valid;
    bit          m_lock_id;
    int          checks;
    int          errors;
    int          cyc;

    regfile_port_arbiter dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .req0     (req[0]),
        .we0      (we[0]),
        .addr0    (addr[0]),
        .wdata0   (wdata[0]),
        .req1     (req[1]),
        .we1      (we[1]),
        .addr1    (addr[1]),
        .wdata1   (wdata[1]),
`ifdef REGFILE_ARB_LOCK_EN
        .lock0    (lock[0]),
        .lock1    (lock[1]),
`endif
        .ack0     (ack0),
        .ack1     (ack1),
        .err0     (err0),
        .err1     (err1),
        .rdata    (rdata),
        .rf_sel   (rf_sel),
        .rf_we    (rf_we),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    function automatic logic [15:0] init_val(input int i);
        return (i == 5) ? 16'h1234 : 16'(16'hA000 + i * 16'h0101);
    endfunction

    // Environment register file: combinational read mux, write on the clock edge.
    always_comb rf_rdata = (rf_sel < 4'd10) ? env_mem[rf_sel] : 16'h0;

    initial begin
        for (int i = 0; i < 10; i++) env_mem[i] = init_val(i);
        forever begin
            @(posedge CLK);
            if (rf_we && rf_sel < 4'd10) env_mem[rf_sel] <= rf_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: decides the winner from the pending requests and returns the expected response.
    function automatic void predict_and_push();
        exp_t e;
        bit   w;
        if (m_lock_valid)             w = m_lock_id;
        else if (req[0] && req[1])    w = !m_last;
        else                          w = req[1];
        m_last  = w;
        e.id    = w;
        e.err   = (addr[w] >= 4'd10);
        e.rdata = 16'h0;
        if (!e.err) begin
            if (we[w]) ref_mem[addr[w]] = wdata[w];
            else       e.rdata = ref_mem[addr[w]];
        end
        m_lock_valid = lock[w];
        m_lock_id    = w;
        exp_q.push_back(e);
    endfunction

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge CLK); #1;
            if (ack0 || ack1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: got no ack in 10 cycles, expected one");
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack0"}, ack0, 0);
        check({tag, "_ack1"}, ack1, 0);
        check({tag, "_err"}, {err0, err1}, 0);
        check({tag, "_rf_we"}, rf_we, 0);
        check({tag, "_rf_sel"}, rf_sel, 0);
        check({tag, "_rf_wdata"}, rf_wdata, 0);
        check({tag, "_rdata"}, rdata, 0);
    endtask

    task automatic do_reset();
        RST_N  = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        m_last = 1'b0;
        m_lock_valid = 1'b0;
        @(posedge CLK); #1;
        check_zero("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    // One isolated access, checking port timing at N+1 and the ack at N+2.
    task automatic single(input bit id, input bit w, input logic [3:0] a, input logic [15:0] d);
        bit legal;
        legal    = (a < 4'd10);
        we[id]   = w;
        addr[id] = a;
        wdata[id] = d;
        lock[id] = 1'b0;
        req[id]  = 1'b1;
        predict_and_push();
        @(posedge CLK); #1;
        check("access_rf_we", rf_we, w && legal);
        check("access_rf_sel", rf_sel, legal ? a : 4'd0);
        if (w && legal) check("access_rf_wdata", rf_wdata, d);
        @(posedge CLK); #1;
        check("ack_latency", id ? ack1 : ack0, 1);
        req[id] = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic new_fields(input bit i);
        req[i]   = 1'b1;
        we[i]    = 1'($urandom_range(0, 1));
        addr[i]  = 4'($urandom_range(0, 11));
        wdata[i] = 16'($urandom);
`ifdef REGFILE_ARB_LOCK_EN
        lock[i]  = ($urandom_range(0, 3) == 0);
`else
        lock[i]  = 1'b0;
`endif
    endtask

    // Scoreboard monitor: pops one expectation per ack.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N && (ack0 || ack1)) begin
                $display("ack t=%0t id=%0d err=%0d rdata=%h", $time, ack1, err0 | err1, rdata);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ack: got ack0=%0d ack1=%0d, expected none", ack0, ack1);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_exclusive", {ack0, ack1}, e.id ? 2'b01 : 2'b10);
                    check("err", {err0, err1}, e.err ? (e.id ? 2'b01 : 2'b10) : 2'b00);
                    if (!e.err) check("rdata", rdata, e.rdata);
                end
            end else if (RST_N && (err0 || err1)) begin
                checks++;
                errors++;
                $display("FAIL err_without_ack: got err0=%0d err1=%0d, expected 0", err0, err1);
            end
        end
    end

    initial begin
        bit got;
        bit w;
        int last_cyc;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 10; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 4'd0; wdata[i] = 16'h0; lock[i] = 1'b0;
        end
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_zero("por");
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        single(1'b0, 1'b1, 4'd3, 16'hBEEF);
        single(1'b1, 1'b0, 4'd5, 16'h0);
        single(1'b0, 1'b1, 4'd12, 16'h7777);
        single(1'b1, 1'b0, 4'd3, 16'h0);
        single(1'b0, 1'b0, 4'd15, 16'h0);

        // Contention from reset: grants alternate starting with requester 1, every 3 cycles.
        do_reset();
        we[0] = 1'b0; addr[0] = 4'd1; req[0] = 1'b1;
        we[1] = 1'b0; addr[1] = 4'd2; req[1] = 1'b1;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            predict_and_push();
            wait_ack(got);
            check("contention_grant", ack1, (k % 2 == 0));
            if (k > 0) check("contention_spacing", cyc - last_cyc, 3);
            last_cyc = cyc;
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        @(posedge CLK); #1;

        // Reset during ACCESS of a write must abort it without an ack or a write.
        single(1'b0, 1'b1, 4'd7, 16'h1111);
        we[0] = 1'b1; addr[0] = 4'd7; wdata[0] = 16'hDEAD; req[0] = 1'b1;
        @(posedge CLK); #1;
        check("abort_rf_we", rf_we, 1);
        #2;
        RST_N = 1'b0;
        req[0] = 1'b0;
        m_last = 1'b0;
        m_lock_valid = 1'b0;
        #1;
        check_zero("abort");
        @(posedge CLK); #1;
        check("abort_no_ack", {ack0, ack1}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        single(1'b0, 1'b0, 4'd7, 16'h0);

`ifdef REGFILE_ARB_LOCK_EN
        // Locked read then write by requester 0 while requester 1 waits.
        we[0] = 1'b0; addr[0] = 4'd2; lock[0] = 1'b1; req[0] = 1'b1;
        predict_and_push();
        wait_ack(got);
        check("lock_first", ack0, 1);
        @(posedge CLK); #1;
        we[0] = 1'b1; addr[0] = 4'd4; wdata[0] = 16'h5A5A; lock[0] = 1'b0;
        we[1] = 1'b0; addr[1] = 4'd4; lock[1] = 1'b0; req[1] = 1'b1;
        predict_and_push();
        wait_ack(got);
        check("lock_second", ack0, 1);
        @(posedge CLK); #1;
        req[0] = 1'b0;
        predict_and_push();
        wait_ack(got);
        check("lock_released", ack1, 1);
        req[1] = 1'b0;
        @(posedge CLK); #1;
`endif

        // Randomized traffic; request fields only change in the IDLE cycle after an ack.
        for (int t = 0; t < 200; t++) begin
            if (!req[0] && !req[1]) begin
                int r;
                repeat ($urandom_range(0, 2)) @(posedge CLK);
                #1;
                r = $urandom_range(1, 3);
                if (r[0]) new_fields(1'b0);
                if (r[1]) new_fields(1'b1);
            end
            predict_and_push();
            wait_ack(got);
            if (!got) begin
                req[0] = 1'b0;
                req[1] = 1'b0;
                exp_q.delete();
                break;
            end
            @(posedge CLK); #1;
            w = m_last;
            if (m_lock_valid || $urandom_range(0, 9) < 7) new_fields(w);
            else req[w] = 1'b0;
            if (req[!w] && $urandom_range(0, 3) == 0) new_fields(!w);
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
